// File: rtl/hqm_sberep_pkg.sv
// ---------------------------------------------------------------------------
// hqm_sberep_pkg : shared sizing and entry types for the sideband repeater FIFOs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hqm_sberep_pkg;

  localparam int FIFO_DEPTH     = 2;
  localparam int LOG_FIFO_DEPTH = $clog2(FIFO_DEPTH);
  localparam int DEF_PLD_W      = 32;

  typedef logic [LOG_FIFO_DEPTH:0] ptr_t;

  typedef struct packed {
    logic                 eom;
    logic                 parity;
    logic [DEF_PLD_W-1:0] payload;
  } entry_t;

endpackage

`default_nettype wire

// File: rtl/hqm_sberep_fifo.sv
// ---------------------------------------------------------------------------
// hqm_sberep_fifo : two-pointer flopped FIFO with flopped full/empty flags
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hqm_sberep_fifo #(
  parameter  int WIDTH = 34,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      wptr,
  output logic [AW:0]      rptr,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      w_inc, r_inc;
  logic             full_q, full_d, empty_q, empty_d;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    full_d  = full_q;
    empty_d = empty_q;
    w_inc   = wptr_q + {{AW{1'b0}}, 1'b1};
    r_inc   = rptr_q + {{AW{1'b0}}, 1'b1};
    if (push) begin
      mem_d[wptr_q[AW-1:0]] = din;
      wptr_d                = w_inc;
    end
    if (pop) begin
      rptr_d = r_inc;
    end
    // Flags only move on a one-sided access; push+pop keeps occupancy.
    if (push && !pop) begin
      empty_d = 1'b0;
      full_d  = (w_inc == {~rptr_q[AW], rptr_q[AW-1:0]});
    end else if (pop && !push) begin
      full_d  = 1'b0;
      empty_d = (r_inc == wptr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign dout  = empty_q ? '0 : mem_q[rptr_q[AW-1:0]];
  assign wptr  = wptr_q;
  assign rptr  = rptr_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

`default_nettype wire

// File: rtl/hqm_sberep_tgt_new.sv
// ---------------------------------------------------------------------------
// hqm_sberep_tgt_new : target-direction PC/NP repeater with PC->NP ordering fence
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hqm_sberep_tgt_new #(
  parameter int INTERNALPLDBIT = 31,
  parameter int FIFO_DEPTH     = hqm_sberep_pkg::FIFO_DEPTH
) (
  input  logic                    agent_clk,
  input  logic                    agent_rst_b,
  input  logic                    sbe_sbi_tmsg_pcput_ep,
  input  logic                    sbe_sbi_tmsg_npput_ep,
  input  logic                    sbe_sbi_tmsg_pceom_ep,
  input  logic                    sbe_sbi_tmsg_npeom_ep,
  input  logic                    sbe_sbi_tmsg_pcparity_ep,
  input  logic                    sbe_sbi_tmsg_npparity_ep,
  input  logic [INTERNALPLDBIT:0] sbe_sbi_tmsg_pcpayload_ep,
  input  logic [INTERNALPLDBIT:0] sbe_sbi_tmsg_nppayload_ep,
  output logic                    sbi_sbe_tmsg_pcfree_ep,
  output logic                    sbi_sbe_tmsg_npfree_ep,
  output logic                    sbe_sbi_tmsg_pcput_ip,
  output logic                    sbe_sbi_tmsg_npput_ip,
  output logic                    sbe_sbi_tmsg_pceom_ip,
  output logic                    sbe_sbi_tmsg_npeom_ip,
  output logic                    sbe_sbi_tmsg_pcparity_ip,
  output logic                    sbe_sbi_tmsg_npparity_ip,
  output logic [INTERNALPLDBIT:0] sbe_sbi_tmsg_pcpayload_ip,
  output logic [INTERNALPLDBIT:0] sbe_sbi_tmsg_nppayload_ip,
  input  logic                    sbi_sbe_tmsg_pcfree_ip,
  input  logic                    sbi_sbe_tmsg_npfree_ip,
  output logic [1:0]              empty_tgt,
  output logic [1:0]              full_tgt
);

  import hqm_sberep_pkg::*;

  localparam int P    = INTERNALPLDBIT + 1;
  localparam int PW   = $clog2(FIFO_DEPTH) + 1;
  localparam int PC_W = P + 2;
  localparam int NP_W = PC_W + PW;

  logic            rst_done_q, rst_done_d;
  logic            pc_full, pc_empty, np_full, np_empty;
  logic [PW-1:0]   pc_wptr, pc_rptr, np_wptr_unused, np_rptr_unused;
  logic [PW-1:0]   np_tag_in, np_head_tag;
  logic            pc_push, np_push, pc_pop, np_pop, fence_ok;
  logic [PC_W-1:0] pc_head;
  logic [NP_W-1:0] np_head;

  always_comb begin
    rst_done_d = 1'b1;
  end

  always_ff @(posedge agent_clk or negedge agent_rst_b) begin
    if (!agent_rst_b) begin
      rst_done_q <= 1'b0;
    end else begin
      rst_done_q <= rst_done_d;
    end
  end

  always_comb begin
    sbi_sbe_tmsg_pcfree_ep = rst_done_q & ~pc_full;
    sbi_sbe_tmsg_npfree_ep = rst_done_q & ~np_full;
    pc_push   = sbe_sbi_tmsg_pcput_ep & sbi_sbe_tmsg_pcfree_ep;
    np_push   = sbe_sbi_tmsg_npput_ep & sbi_sbe_tmsg_npfree_ep;
    // NP tag marks the PC write position including any PC flit pushed alongside it.
    np_tag_in = pc_push ? (pc_wptr + {{(PW-1){1'b0}}, 1'b1}) : pc_wptr;
    np_head_tag = np_head[NP_W-1 -: PW];
    fence_ok  = (pc_rptr == np_head_tag) | pc_empty;
    pc_pop    = ~pc_empty & sbi_sbe_tmsg_pcfree_ip;
    np_pop    = ~np_empty & sbi_sbe_tmsg_npfree_ip & fence_ok;
  end

  hqm_sberep_fifo #(.WIDTH(PC_W), .DEPTH(FIFO_DEPTH)) u_pc_fifo (
    .clk   (agent_clk),
    .rst_n (agent_rst_b),
    .push  (pc_push),
    .din   ({sbe_sbi_tmsg_pceom_ep, sbe_sbi_tmsg_pcparity_ep, sbe_sbi_tmsg_pcpayload_ep}),
    .pop   (pc_pop),
    .dout  (pc_head),
    .wptr  (pc_wptr),
    .rptr  (pc_rptr),
    .full  (pc_full),
    .empty (pc_empty)
  );

  hqm_sberep_fifo #(.WIDTH(NP_W), .DEPTH(FIFO_DEPTH)) u_np_fifo (
    .clk   (agent_clk),
    .rst_n (agent_rst_b),
    .push  (np_push),
    .din   ({np_tag_in, sbe_sbi_tmsg_npeom_ep, sbe_sbi_tmsg_npparity_ep, sbe_sbi_tmsg_nppayload_ep}),
    .pop   (np_pop),
    .dout  (np_head),
    .wptr  (np_wptr_unused),
    .rptr  (np_rptr_unused),
    .full  (np_full),
    .empty (np_empty)
  );

  assign sbe_sbi_tmsg_pcput_ip     = pc_pop;
  assign sbe_sbi_tmsg_npput_ip     = np_pop;
  assign sbe_sbi_tmsg_pceom_ip     = pc_head[P+1];
  assign sbe_sbi_tmsg_pcparity_ip  = pc_head[P];
  assign sbe_sbi_tmsg_pcpayload_ip = pc_head[P-1:0];
  assign sbe_sbi_tmsg_npeom_ip     = np_head[P+1];
  assign sbe_sbi_tmsg_npparity_ip  = np_head[P];
  assign sbe_sbi_tmsg_nppayload_ip = np_head[P-1:0];
  assign empty_tgt                 = {np_empty, pc_empty};
  assign full_tgt                  = {np_full, pc_full};

  a_pc_put_legal: assert property (@(posedge agent_clk) disable iff (!agent_rst_b)
    sbe_sbi_tmsg_pcput_ep |-> sbi_sbe_tmsg_pcfree_ep);
  a_np_put_legal: assert property (@(posedge agent_clk) disable iff (!agent_rst_b)
    sbe_sbi_tmsg_npput_ep |-> sbi_sbe_tmsg_npfree_ep);

endmodule

`default_nettype wire

// File: tb/tb_hqm_sberep_tgt_new.sv
// ---------------------------------------------------------------------------
// tb_hqm_sberep_tgt_new : directed self-checking bench for the target repeater
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hqm_sberep_tgt_new;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        pc_put_ep, np_put_ep, pc_eom_ep, np_eom_ep, pc_par_ep, np_par_ep;
  logic [31:0] pc_pld_ep, np_pld_ep;
  logic        pc_free_ep, np_free_ep;
  logic        pc_put_ip, np_put_ip, pc_eom_ip, np_eom_ip, pc_par_ip, np_par_ip;
  logic [31:0] pc_pld_ip, np_pld_ip;
  logic        pc_free_ip, np_free_ip;
  logic [1:0]  empty_tgt, full_tgt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hqm_sberep_tgt_new #(.INTERNALPLDBIT(31), .FIFO_DEPTH(2)) dut (
    .agent_clk                 (clk),
    .agent_rst_b               (rst_b),
    .sbe_sbi_tmsg_pcput_ep     (pc_put_ep),
    .sbe_sbi_tmsg_npput_ep     (np_put_ep),
    .sbe_sbi_tmsg_pceom_ep     (pc_eom_ep),
    .sbe_sbi_tmsg_npeom_ep     (np_eom_ep),
    .sbe_sbi_tmsg_pcparity_ep  (pc_par_ep),
    .sbe_sbi_tmsg_npparity_ep  (np_par_ep),
    .sbe_sbi_tmsg_pcpayload_ep (pc_pld_ep),
    .sbe_sbi_tmsg_nppayload_ep (np_pld_ep),
    .sbi_sbe_tmsg_pcfree_ep    (pc_free_ep),
    .sbi_sbe_tmsg_npfree_ep    (np_free_ep),
    .sbe_sbi_tmsg_pcput_ip     (pc_put_ip),
    .sbe_sbi_tmsg_npput_ip     (np_put_ip),
    .sbe_sbi_tmsg_pceom_ip     (pc_eom_ip),
    .sbe_sbi_tmsg_npeom_ip     (np_eom_ip),
    .sbe_sbi_tmsg_pcparity_ip  (pc_par_ip),
    .sbe_sbi_tmsg_npparity_ip  (np_par_ip),
    .sbe_sbi_tmsg_pcpayload_ip (pc_pld_ip),
    .sbe_sbi_tmsg_nppayload_ip (np_pld_ip),
    .sbi_sbe_tmsg_pcfree_ip    (pc_free_ip),
    .sbi_sbe_tmsg_npfree_ip    (np_free_ip),
    .empty_tgt                 (empty_tgt),
    .full_tgt                  (full_tgt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    settle();
    checks++;
    if ({pc_free_ep, np_free_ep} !== 2'b00) begin
      errors++; $display("FAIL reset_free got %b exp 00", {pc_free_ep, np_free_ep});
    end
    checks++;
    if ({empty_tgt, full_tgt} !== 4'b1100) begin
      errors++; $display("FAIL reset_flags got empty=%b full=%b exp empty=11 full=00", empty_tgt, full_tgt);
    end
    checks++;
    if ({pc_put_ip, np_put_ip, pc_eom_ip, np_eom_ip, pc_par_ip, np_par_ip, pc_pld_ip, np_pld_ip} !== 70'd0) begin
      errors++; $display("FAIL reset_ip_outputs got nonzero pc_pld=%h np_pld=%h exp 0", pc_pld_ip, np_pld_ip);
    end
    rst_b = 1'b1;
    settle();
    checks++;
    if ({pc_free_ep, np_free_ep} !== 2'b00) begin
      errors++; $display("FAIL release_cycle_free got %b exp 00", {pc_free_ep, np_free_ep});
    end
    tick();
    checks++;
    if ({pc_free_ep, np_free_ep, empty_tgt} !== 4'b1111) begin
      errors++; $display("FAIL post_release got free=%b empty=%b exp free=11 empty=11", {pc_free_ep, np_free_ep}, empty_tgt);
    end
  endtask

  task automatic test_back_to_back();
    pc_free_ip = 1'b0;
    pc_put_ep = 1'b1; pc_pld_ep = 32'hA5A5_0001; pc_eom_ep = 1'b0; pc_par_ep = 1'b1;
    settle();
    checks++;
    if (pc_free_ep !== 1'b1) begin
      errors++; $display("FAIL b2b_free1 got %b exp 1", pc_free_ep);
    end
    tick();
    pc_pld_ep = 32'hA5A5_0002; pc_eom_ep = 1'b1; pc_par_ep = 1'b0;
    settle();
    checks++;
    if ({pc_free_ep, pc_put_ip, pc_pld_ip} !== {2'b10, 32'hA5A5_0001}) begin
      errors++; $display("FAIL b2b_second got free=%b put=%b pld=%h exp free=1 put=0 pld=a5a50001", pc_free_ep, pc_put_ip, pc_pld_ip);
    end
    tick();
    pc_put_ep = 1'b0; pc_pld_ep = '0; pc_eom_ep = 1'b0; pc_par_ep = 1'b0;
    settle();
    checks++;
    if ({full_tgt, empty_tgt, pc_free_ep} !== 5'b01_10_0) begin
      errors++; $display("FAIL b2b_full got full=%b empty=%b free=%b exp full=01 empty=10 free=0", full_tgt, empty_tgt, pc_free_ep);
    end
    pc_free_ip = 1'b1;
    settle();
    checks++;
    if ({pc_put_ip, pc_eom_ip, pc_par_ip, pc_pld_ip} !== {3'b101, 32'hA5A5_0001}) begin
      errors++; $display("FAIL b2b_out1 got put=%b eom=%b par=%b pld=%h exp 1 0 1 a5a50001", pc_put_ip, pc_eom_ip, pc_par_ip, pc_pld_ip);
    end
    tick();
    checks++;
    if ({pc_put_ip, pc_eom_ip, pc_par_ip, pc_pld_ip, full_tgt} !== {3'b110, 32'hA5A5_0002, 2'b00}) begin
      errors++; $display("FAIL b2b_out2 got put=%b eom=%b par=%b pld=%h full=%b exp 1 1 0 a5a50002 00", pc_put_ip, pc_eom_ip, pc_par_ip, pc_pld_ip, full_tgt);
    end
    tick();
    checks++;
    if ({pc_put_ip, pc_pld_ip, empty_tgt} !== {1'b0, 32'h0, 2'b11}) begin
      errors++; $display("FAIL b2b_drained got put=%b pld=%h empty=%b exp 0 0 11", pc_put_ip, pc_pld_ip, empty_tgt);
    end
    pc_free_ip = 1'b0;
  endtask

  task automatic test_fence();
    np_free_ip = 1'b1; pc_free_ip = 1'b0;
    pc_put_ep = 1'b1; pc_pld_ep = 32'h1111_0001; pc_eom_ep = 1'b1;
    tick();
    pc_put_ep = 1'b0; pc_pld_ep = '0; pc_eom_ep = 1'b0;
    np_put_ep = 1'b1; np_pld_ep = 32'h2222_0001; np_eom_ep = 1'b1;
    settle();
    checks++;
    if (np_free_ep !== 1'b1) begin
      errors++; $display("FAIL fence_npfree got %b exp 1", np_free_ep);
    end
    tick();
    np_put_ep = 1'b0; np_pld_ep = '0; np_eom_ep = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if ({np_put_ip, empty_tgt} !== 3'b0_00) begin
        errors++; $display("FAIL fence_hold%0d got npput=%b empty=%b exp npput=0 empty=00", i, np_put_ip, empty_tgt);
      end
      if (i == 0) tick();
    end
    pc_free_ip = 1'b1;
    settle();
    checks++;
    if ({pc_put_ip, pc_pld_ip, np_put_ip} !== {1'b1, 32'h1111_0001, 1'b0}) begin
      errors++; $display("FAIL fence_pc_first got pcput=%b pld=%h npput=%b exp 1 11110001 0", pc_put_ip, pc_pld_ip, np_put_ip);
    end
    tick();
    checks++;
    if ({pc_put_ip, np_put_ip, np_pld_ip, np_eom_ip} !== {2'b01, 32'h2222_0001, 1'b1}) begin
      errors++; $display("FAIL fence_np_next got pcput=%b npput=%b pld=%h eom=%b exp 0 1 22220001 1", pc_put_ip, np_put_ip, np_pld_ip, np_eom_ip);
    end
    tick();
    checks++;
    if (empty_tgt !== 2'b11) begin
      errors++; $display("FAIL fence_drained got empty=%b exp 11", empty_tgt);
    end
  endtask

  task automatic test_same_cycle();
    pc_free_ip = 1'b1; np_free_ip = 1'b1;
    pc_put_ep = 1'b1; pc_pld_ep = 32'h3333_0003;
    np_put_ep = 1'b1; np_pld_ep = 32'h4444_0004;
    tick();
    pc_put_ep = 1'b0; pc_pld_ep = '0; np_put_ep = 1'b0; np_pld_ep = '0;
    settle();
    checks++;
    if ({pc_put_ip, pc_pld_ip, np_put_ip} !== {1'b1, 32'h3333_0003, 1'b0}) begin
      errors++; $display("FAIL same_n1 got pcput=%b pld=%h npput=%b exp 1 33330003 0", pc_put_ip, pc_pld_ip, np_put_ip);
    end
    tick();
    checks++;
    if ({pc_put_ip, np_put_ip, np_pld_ip} !== {2'b01, 32'h4444_0004}) begin
      errors++; $display("FAIL same_n2 got pcput=%b npput=%b pld=%h exp 0 1 44440004", pc_put_ip, np_put_ip, np_pld_ip);
    end
    tick();
  endtask

  task automatic test_np_only();
    np_free_ip = 1'b1;
    np_put_ep = 1'b1; np_pld_ep = 32'h1234_5678; np_par_ep = 1'b1; np_eom_ep = 1'b1;
    settle();
    checks++;
    if (np_put_ip !== 1'b0) begin
      errors++; $display("FAIL np_no_flowthrough got npput=%b exp 0", np_put_ip);
    end
    tick();
    np_put_ep = 1'b0; np_pld_ep = '0; np_par_ep = 1'b0; np_eom_ep = 1'b0;
    settle();
    checks++;
    if ({np_put_ip, np_par_ip, np_eom_ip, np_pld_ip} !== {3'b111, 32'h1234_5678}) begin
      errors++; $display("FAIL np_latency got put=%b par=%b eom=%b pld=%h exp 1 1 1 12345678", np_put_ip, np_par_ip, np_eom_ip, np_pld_ip);
    end
    tick();
  endtask

  task automatic test_np_full();
    np_free_ip = 1'b0;
    np_put_ep = 1'b1; np_pld_ep = 32'h6666_0001;
    tick();
    np_pld_ep = 32'h6666_0002;
    tick();
    np_put_ep = 1'b0; np_pld_ep = '0;
    settle();
    checks++;
    if ({full_tgt, np_free_ep, pc_free_ep} !== 4'b10_0_1) begin
      errors++; $display("FAIL np_full got full=%b npfree=%b pcfree=%b exp 10 0 1", full_tgt, np_free_ep, pc_free_ep);
    end
    np_free_ip = 1'b1;
    tick();
    checks++;
    if ({np_put_ip, np_pld_ip} !== {1'b1, 32'h6666_0002}) begin
      errors++; $display("FAIL np_full_drain got put=%b pld=%h exp 1 66660002", np_put_ip, np_pld_ip);
    end
    tick();
  endtask

  task automatic test_stream();
    logic [31:0] exp_pld;
    pc_free_ip = 1'b0;
    pc_put_ep = 1'b1; pc_pld_ep = 32'h5000_0000; pc_par_ep = 1'b0;
    tick();
    pc_free_ip = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      pc_pld_ep = 32'h5000_0000 + i;
      pc_par_ep = i[0];
      settle();
      exp_pld = 32'h5000_0000 + (i - 1);
      checks++;
      if ({pc_put_ip, pc_par_ip, pc_pld_ip, full_tgt[0], empty_tgt[0], pc_free_ep} !== {1'b1, exp_pld[0], exp_pld, 3'b001}) begin
        errors++; $display("FAIL stream%0d got put=%b par=%b pld=%h full=%b empty=%b free=%b exp pld=%h", i, pc_put_ip, pc_par_ip, pc_pld_ip, full_tgt[0], empty_tgt[0], pc_free_ep, exp_pld);
      end
      tick();
    end
    pc_put_ep = 1'b0; pc_pld_ep = '0; pc_par_ep = 1'b0;
    settle();
    checks++;
    if ({pc_put_ip, pc_pld_ip} !== {1'b1, 32'h5000_0014}) begin
      errors++; $display("FAIL stream_last got put=%b pld=%h exp 1 50000014", pc_put_ip, pc_pld_ip);
    end
    tick();
    checks++;
    if (empty_tgt !== 2'b11) begin
      errors++; $display("FAIL stream_drained got empty=%b exp 11", empty_tgt);
    end
  endtask

  initial begin
    rst_b = 1'b0;
    pc_put_ep = 1'b0; np_put_ep = 1'b0; pc_eom_ep = 1'b0; np_eom_ep = 1'b0;
    pc_par_ep = 1'b0; np_par_ep = 1'b0; pc_pld_ep = '0; np_pld_ep = '0;
    pc_free_ip = 1'b0; np_free_ip = 1'b0;
    repeat (3) tick();
    test_reset();
    test_back_to_back();
    test_fence();
    test_same_cycle();
    test_np_only();
    test_np_full();
    test_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
